// File: rtl/ibex_instr_mem_responder.sv
// Instruction-side memory model for an Ibex-style fetch port: combinational grant,
// fixed-latency in-order responses from an internal word array with a backdoor write port.
module ibex_instr_mem_responder #(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] ErrBase        = 32'h0001_0000,
  parameter logic [31:0] ErrBytes       = 32'h100,
  localparam int unsigned AW            = $clog2(MemWords),
  localparam int unsigned OW            = $clog2(NumOutstanding + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          gnt_stall_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [31:0]   mem_wdata_i,
  output logic [OW-1:0] outstanding_o
);

  localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CW = (Latency > 1) ? $clog2(Latency) : 1;

  // Handshake: a request transfers in any cycle where instr_req_i && instr_gnt_o;
  // the address is sampled only then. Each transfer yields exactly one rvalid
  // pulse Latency cycles later, in grant order, with rdata/err valid only with it.

  logic [31:0]             mem_q [MemWords];

  logic [OW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [31:0]             data_q [NumOutstanding];
  logic [NumOutstanding-1:0] err_q;
  logic [CW-1:0]           cd_q [NumOutstanding];

  logic                    full;
  logic                    gnt;
  logic                    rvalid;
  logic                    range_err;
  logic                    win_err;
  logic                    cap_err;
  logic [31:0]             cap_data;
  logic [32:0]             addr_x;
  logic [32:0]             win_lo;
  logic [32:0]             win_hi;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NumOutstanding - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Error decode; the window bounds use 33 bits so ErrBase+ErrBytes cannot wrap.
  always_comb begin
    addr_x    = {1'b0, instr_addr_i};
    win_lo    = {1'b0, ErrBase};
    win_hi    = {1'b0, ErrBase} + {1'b0, ErrBytes};
    range_err = ({2'b00, instr_addr_i[31:2]} >= 32'(MemWords));
    win_err   = (ErrBytes != 32'h0) && (addr_x >= win_lo) && (addr_x < win_hi);
    cap_err   = range_err | win_err;
    cap_data  = cap_err ? 32'h0 : mem_q[instr_addr_i[AW+1:2]];
  end

  // Fullness looks only at the registered count, so a retiring head frees its slot next cycle.
  always_comb begin
    full   = (cnt_q == OW'(NumOutstanding));
    gnt    = instr_req_i & ~gnt_stall_i & ~full & ~rst_i;
    rvalid = (cnt_q != '0) & (cd_q[rd_ptr_q] == '0) & ~rst_i;
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (gnt && !rvalid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!gnt && rvalid) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (gnt) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rvalid) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
      for (int i = 0; i < NumOutstanding; i++) begin
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < NumOutstanding; i++) begin
        if (gnt && (wr_ptr_q == PW'(i))) begin
          data_q[i] <= cap_data;
          err_q[i]  <= cap_err;
          cd_q[i]   <= CW'(Latency - 1);
        end else if (cd_q[i] != '0) begin
          cd_q[i] <= cd_q[i] - 1'b1;
        end
      end
    end
  end

  // Array is deliberately not reset; a same-cycle grant reads the pre-write word.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      mem_q[mem_waddr_i] <= mem_wdata_i;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? data_q[rd_ptr_q] : 32'h0;
  assign instr_err_o    = rvalid & err_q[rd_ptr_q];
  assign outstanding_o  = cnt_q;

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= OW'(NumOutstanding));

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench for ibex_instr_mem_responder: four parameterisations share one stimulus
// bus; each scenario task checks the instance whose parameters it targets.
module tb_ibex_instr_mem_responder;

  localparam logic [31:0] A0  = 32'h1111_0000;
  localparam logic [31:0] A1  = 32'h2222_0001;
  localparam logic [31:0] A2  = 32'h3333_0002;
  localparam logic [31:0] A3  = 32'h4444_0003;
  localparam logic [31:0] DX  = 32'hDEAD_0005;
  localparam logic [31:0] DY  = 32'hBEEF_0005;
  localparam logic [31:0] DZ  = 32'hCAFE_0005;
  localparam logic [31:0] D3F = 32'h0000_3F3F;
  localparam logic [31:0] D40 = 32'h4040_4040;
  localparam logic [31:0] D4F = 32'h4F4F_0000;
  localparam logic [31:0] D50 = 32'h5050_5050;
  localparam logic [31:0] DFF = 32'hFFFF_03FF;

  logic        clk, rst, req, stall, we;
  logic [31:0] addr, wdata;
  logic [9:0]  waddr;

  logic gnt_1, rv_1, er_1; logic [31:0] rd_1; logic [1:0] os_1;
  logic gnt_3, rv_3, er_3; logic [31:0] rd_3; logic [1:0] os_3;
  logic gnt_4, rv_4, er_4; logic [31:0] rd_4; logic [1:0] os_4;
  logic gnt_w, rv_w, er_w; logic [31:0] rd_w; logic [1:0] os_w;

  int checks = 0;
  int failures = 0;

  ibex_instr_mem_responder u1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_1), .instr_rvalid_o(rv_1), .instr_rdata_o(rd_1), .instr_err_o(er_1),
    .gnt_stall_i(stall), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .outstanding_o(os_1));

  ibex_instr_mem_responder #(.NumOutstanding(2), .Latency(3)) u3 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_3), .instr_rvalid_o(rv_3), .instr_rdata_o(rd_3), .instr_err_o(er_3),
    .gnt_stall_i(stall), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .outstanding_o(os_3));

  ibex_instr_mem_responder #(.NumOutstanding(2), .Latency(4)) u4 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_4), .instr_rvalid_o(rv_4), .instr_rdata_o(rd_4), .instr_err_o(er_4),
    .gnt_stall_i(stall), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .outstanding_o(os_4));

  ibex_instr_mem_responder #(.ErrBase(32'h100), .ErrBytes(32'h40)) uw (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_w), .instr_rvalid_o(rv_w), .instr_rdata_o(rd_w), .instr_err_o(er_w),
    .gnt_stall_i(stall), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .outstanding_o(os_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; stall = 1'b0; we = 1'b0;
    addr = 32'h0; wdata = 32'h0; waddr = '0;
    #2;
    @(negedge clk);
    checks++;
    if ({gnt_1, rv_1, er_1, rd_1, os_1} !== 37'h0) begin
      failures++;
      $display("FAIL reset_u1 got=%h exp=0", {gnt_1, rv_1, er_1, rd_1, os_1});
    end
    checks++;
    if ({gnt_4, rv_4, er_4, rd_4, os_4} !== 37'h0) begin
      failures++;
      $display("FAIL reset_u4 got=%h exp=0", {gnt_4, rv_4, er_4, rd_4, os_4});
    end
    cyc();
    rst = 1'b0;
    req = 1'b0;
    cyc();
  endtask

  task automatic preload();
    logic [9:0]  idx [10] = '{10'h0, 10'h1, 10'h2, 10'h3, 10'h5, 10'h3F, 10'h40, 10'h4F, 10'h50, 10'h3FF};
    logic [31:0] val [10] = '{A0, A1, A2, A3, DX, D3F, D40, D4F, D50, DFF};
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; waddr = idx[i]; wdata = val[i];
      cyc();
    end
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  gnt_exp = 6'b001111;
    logic [5:0]  rv_exp  = 6'b011110;
    logic [31:0] rd_exp [6] = '{32'h0, A0, A1, A2, A3, 32'h0};
    for (int c = 0; c < 6; c++) begin
      req  = (c < 4);
      addr = 32'(c * 4);
      @(negedge clk);
      checks++;
      if ({gnt_1, rv_1, er_1, rd_1} !== {gnt_exp[c], rv_exp[c], 1'b0, rd_exp[c]}) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", c, {gnt_1, rv_1, er_1, rd_1},
                 {gnt_exp[c], rv_exp[c], 1'b0, rd_exp[c]});
      end
      cyc();
    end
    idle(8);
  endtask

  task automatic test_backpressure();
    logic [7:0]  gnt_exp = 8'b00010011;
    logic [7:0]  rv_exp  = 8'b10011000;
    logic [1:0]  os_exp [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [31:0] rd_exp;
    for (int c = 0; c < 8; c++) begin
      req  = (c < 5);
      addr = 32'h0;
      rd_exp = rv_exp[c] ? A0 : 32'h0;
      @(negedge clk);
      checks++;
      if ({gnt_3, rv_3, er_3, rd_3, os_3} !== {gnt_exp[c], rv_exp[c], 1'b0, rd_exp, os_exp[c]}) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, {gnt_3, rv_3, er_3, rd_3, os_3},
                 {gnt_exp[c], rv_exp[c], 1'b0, rd_exp, os_exp[c]});
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (os_3 !== 2'd0) begin
      failures++;
      $display("FAIL backpressure_drain got=%0d exp=0", os_3);
    end
    idle(8);
  endtask

  task automatic test_errors();
    logic [31:0] a    [9] = '{32'h0001_0040, 32'h0000_1000, 32'h0001_0100, 32'h0000_0FFC,
                              32'h0000_0100, 32'h0000_013C, 32'h0000_0140, 32'h0000_00FC,
                              32'h0000_0103};
    logic [8:0]  e1   = 9'b000000111;
    logic [8:0]  ew   = 9'b100110111;
    logic [31:0] d    [9] = '{32'h0, 32'h0, 32'h0, DFF, D40, D4F, D50, D3F, D40};
    logic [31:0] x1, xw;
    for (int i = 0; i < 9; i++) begin
      req = 1'b1; addr = a[i];
      cyc();
      req = 1'b0; addr = 32'hFFFF_FFFF;
      x1 = e1[i] ? 32'h0 : d[i];
      xw = ew[i] ? 32'h0 : d[i];
      @(negedge clk);
      checks++;
      if ({rv_1, er_1, rd_1} !== {1'b1, e1[i], x1}) begin
        failures++;
        $display("FAIL err_u1 addr=%h got=%h exp=%h", a[i], {rv_1, er_1, rd_1}, {1'b1, e1[i], x1});
      end
      checks++;
      if ({rv_w, er_w, rd_w} !== {1'b1, ew[i], xw}) begin
        failures++;
        $display("FAIL err_win addr=%h got=%h exp=%h", a[i], {rv_w, er_w, rd_w}, {1'b1, ew[i], xw});
      end
      cyc();
    end
    idle(8);
  endtask

  task automatic test_collision();
    logic [4:0]  rv1_exp = 5'b00110;
    logic [4:0]  rv3_exp = 5'b11000;
    logic [31:0] rd1_exp [5] = '{32'h0, DX, DY, 32'h0, 32'h0};
    logic [31:0] rd3_exp [5] = '{32'h0, 32'h0, 32'h0, DX, DY};
    for (int c = 0; c < 5; c++) begin
      req   = (c < 2);
      addr  = 32'h14;
      we    = (c < 2);
      waddr = 10'd5;
      wdata = (c == 0) ? DY : DZ;
      @(negedge clk);
      checks++;
      if ({rv_1, rd_1, rv_3, rd_3} !== {rv1_exp[c], rd1_exp[c], rv3_exp[c], rd3_exp[c]}) begin
        failures++;
        $display("FAIL collision cyc=%0d got=%h exp=%h", c, {rv_1, rd_1, rv_3, rd_3},
                 {rv1_exp[c], rd1_exp[c], rv3_exp[c], rd3_exp[c]});
      end
      cyc();
    end
    idle(8);
    req = 1'b1; addr = 32'h14;
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rv_1, rd_1} !== {1'b1, DZ}) begin
      failures++;
      $display("FAIL collision_refetch got=%h exp=%h", {rv_1, rd_1}, {1'b1, DZ});
    end
    idle(8);
  endtask

  task automatic test_stall();
    stall = 1'b1; req = 1'b1; addr = 32'h8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_1, os_1, rv_1} !== 4'b0) begin
        failures++;
        $display("FAIL stall cyc=%0d got=%b exp=0000", c, {gnt_1, os_1, rv_1});
      end
      cyc();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_1 !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got=%b exp=1", gnt_1);
    end
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rv_1, er_1, rd_1} !== {2'b10, A2}) begin
      failures++;
      $display("FAIL stall_resp got=%h exp=%h", {rv_1, er_1, rd_1}, {2'b10, A2});
    end
    idle(8);
  endtask

  task automatic test_reset_midflight();
    logic [5:0] rv_exp = 6'b010000;
    logic [31:0] rd_exp;
    req = 1'b1; addr = 32'h0; cyc();
    addr = 32'h4; cyc();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (os_4 !== 2'd2) begin
      failures++;
      $display("FAIL midflight_pre got=%0d exp=2", os_4);
    end
    cyc();
    rst = 1'b1; req = 1'b1; addr = 32'h8;
    @(negedge clk);
    checks++;
    if ({gnt_4, rv_4, os_4} !== 4'b0) begin
      failures++;
      $display("FAIL midflight_inreset got=%b exp=0000", {gnt_4, rv_4, os_4});
    end
    cyc();
    rst = 1'b0; req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({rv_4, os_4} !== 3'b0) begin
        failures++;
        $display("FAIL midflight_quiet cyc=%0d got=%b exp=000", c, {rv_4, os_4});
      end
      cyc();
    end
    for (int c = 0; c < 6; c++) begin
      req = (c == 0); addr = 32'hC;
      rd_exp = rv_exp[c] ? A3 : 32'h0;
      @(negedge clk);
      checks++;
      if ({rv_4, rd_4} !== {rv_exp[c], rd_exp}) begin
        failures++;
        $display("FAIL midflight_fresh cyc=%0d got=%h exp=%h", c, {rv_4, rd_4}, {rv_exp[c], rd_exp});
      end
      cyc();
    end
    idle(8);
  endtask

  task automatic test_reset_release();
    rst = 1'b1; req = 1'b1; addr = 32'h4;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_1, gnt_4} !== 2'b00) begin
        failures++;
        $display("FAIL release_inreset cyc=%0d got=%b exp=00", c, {gnt_1, gnt_4});
      end
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt_1, gnt_4} !== 2'b11) begin
      failures++;
      $display("FAIL release_first_gnt got=%b exp=11", {gnt_1, gnt_4});
    end
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rv_1, er_1, rd_1} !== {2'b10, A1}) begin
      failures++;
      $display("FAIL release_persist got=%h exp=%h", {rv_1, er_1, rd_1}, {2'b10, A1});
    end
    idle(8);
  endtask

  initial begin
    test_reset();
    preload();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_collision();
    test_stall();
    test_reset_midflight();
    test_reset_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_instr_mem_responder.md
IBEX_INSTR_MEM_RESPONDER -- requirements
Module: ibex_instr_mem_responder

Interface
REQ-001 The block SHALL have parameter NumOutstanding, default 2, giving the maximum number of granted requests not yet answered (range 1..4).
REQ-002 The block SHALL have parameter Latency, default 1, giving the cycles from grant to rvalid (range 1..15).
REQ-003 The block SHALL have parameter MemWords, default 1024, giving the internal 32-bit word array depth (power of two); AW = clog2(MemWords).
REQ-004 The block SHALL have parameter ErrBase, default 32'h0001_0000, giving the byte base of the error window.
REQ-005 The block SHALL have parameter ErrBytes, default 32'h100, giving the byte size of the error window; 0 disables the window.
REQ-006 The block SHALL have these ports, one per line (name, direction, width, meaning):
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
instr_req_i  in  1  fetch request valid
instr_addr_i  in  32  fetch byte address; bits [1:0] ignored
instr_gnt_o  out  1  request accepted this cycle
instr_rvalid_o  out  1  response valid, one cycle per granted request
instr_rdata_o  out  32  response data
instr_err_o  out  1  response bus error
gnt_stall_i  in  1  test hook: forces instr_gnt_o low
mem_we_i  in  1  backdoor word write enable
mem_waddr_i  in  AW  backdoor word index
mem_wdata_i  in  32  backdoor write data
outstanding_o  out  clog2(NumOutstanding+1)  granted-but-unanswered count

Function
REQ-007 The block SHALL drive instr_gnt_o = instr_req_i & ~gnt_stall_i & (outstanding < NumOutstanding), combinationally, in the same cycle as the request.
REQ-008 Fullness SHALL be judged on the registered count only: when full, a response retiring in the same cycle SHALL NOT free a slot until the following cycle.
REQ-009 On grant, the block SHALL capture the response into an in-order queue: data = mem[addr[AW+1:2]] and err = the error condition.
REQ-010 The error condition SHALL be addr[31:2] >= MemWords, or ErrBytes != 0 and ErrBase <= addr < ErrBase+ErrBytes; the comparison SHALL be computed in 33 bits so the window does not wrap.
REQ-011 When err is set, the captured data SHALL be 32'h0.
REQ-012 Each queue entry SHALL carry a countdown loaded with Latency-1 at grant and decremented every cycle while it is nonzero.
REQ-013 The head entry SHALL be issued with instr_rvalid_o=1 in the cycle its countdown reaches 0, and SHALL be popped in that same cycle.
REQ-014 A request granted in cycle T SHALL therefore respond in cycle T+Latency, exactly once.
REQ-015 Responses SHALL be returned strictly in grant order, with no gaps beyond those required by Latency.
REQ-016 instr_rvalid_o SHALL be high for exactly one cycle per grant.
REQ-017 When instr_rvalid_o=0, instr_rdata_o SHALL be 0 and instr_err_o SHALL be 0.
REQ-018 Simultaneous grant and response SHALL be supported: outstanding_o is unchanged and the queue pointers each advance by one.
REQ-019 The queue pointers SHALL wrap modulo NumOutstanding.
REQ-020 On a backdoor write in the same cycle as a grant to the same word, the grant SHALL capture the old data; the write SHALL be visible from the next cycle.
REQ-021 Backdoor writes SHALL NOT alter responses already captured in the queue.
REQ-022 outstanding_o SHALL equal the number of grants minus the number of responses since reset, and SHALL never exceed NumOutstanding.
REQ-023 instr_addr_i SHALL be sampled only in the cycle instr_gnt_o=1; the address in a non-granted cycle SHALL have no effect.

Reset
REQ-024 While rst_i=1, the block SHALL hold instr_gnt_o=0 and instr_rvalid_o=0 (both asynchronously), with instr_rdata_o=0, instr_err_o=0, outstanding_o=0, and the queue pointers and countdowns cleared.
REQ-025 Reset during operation SHALL discard all outstanding requests; no rvalid for a pre-reset grant SHALL ever appear after rst_i falls.
REQ-026 The memory array SHALL NOT be reset; its contents SHALL persist across rst_i.
REQ-027 The first grant SHALL be possible in the first cycle after rst_i deasserts.

Verification
REQ-028 Back-to-back: Latency=1, mem[0..3]=A0..A3, req held high with addr 0,4,8,C -> gnt every cycle; rvalid cycles T+1..T+4 with rdata A0..A3, err=0.
REQ-029 Backpressure: NumOutstanding=2, Latency=3, req held high -> gnt in cycles 0 and 1, low in 2 and 3; rvalid in cycles 3 and 4; outstanding_o sequence 1,2,2,1,...
REQ-030 Errors: addr 32'h0001_0040 -> err=1, rdata=0; addr 4*MemWords -> err=1; addr 32'h0001_0100 (window end) -> err=0 only if its word index < MemWords, else err=1 via the range check.
REQ-031 Write/read collision: mem[5]=X; mem_we_i writes Y to index 5 in the same cycle as a grant of addr 0x14 -> response rdata=X; the next fetch of 0x14 -> Y.
REQ-032 Reset mid-flight: Latency=4, two grants, then rst_i asserted for 1 cycle one cycle later -> no rvalid for 10 cycles after release; outstanding_o=0; a fresh fetch responds normally.
REQ-033 Stall: gnt_stall_i=1 with req=1 for 5 cycles -> gnt=0 and outstanding_o=0 throughout; on release, grant occurs in the same cycle.
